sram_ctrl: RTL

Parametrised single-port controller for the board's asynchronous SRAM (IS61LV25616-class, 10 ns).
- Replaces hard-coded one-shot SRAM pin driving with a valid/ready request port and a one-cycle read-response pulse.
- Supports reads, byte-masked writes and programmable wait states.
- Owns the tristate DQ bus so user logic never drives SRAM pins directly.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_dq_pad.sv | 30 +++
 rtl/sram_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the asynchronous SRAM controller.
package sram_pkg;

  localparam int DEF_ADDR_W = 18;
  localparam int DEF_DATA_W = 16;
  localparam int WAIT_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ACC,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD
  } sram_state_t;

  // The controller owns DQ for the whole write sequence, setup through hold.
  function automatic logic drives_dq(sram_state_t s);
    return (s == WR_SETUP) || (s == WR_STROBE) || (s == WR_HOLD);
  endfunction

endpackage

// File: rtl/sram_dq_pad.sv
// Tristate DQ buffer: registered output data and enable, registered input capture.
module sram_dq_pad #(
  parameter int DATA_W = 16
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              dq_oe_nxt,
  input  logic [DATA_W-1:0] dq_out_nxt,
  output logic [DATA_W-1:0] dq_in,
  inout  wire  [DATA_W-1:0] SRAM_DQ
);

  logic              oe_q;
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      oe_q   <= 1'b0;
      dout_q <= '0;
      dq_in  <= '0;
    end else begin
      oe_q   <= dq_oe_nxt;
      dout_q <= dq_out_nxt;
      dq_in  <= SRAM_DQ;
    end
  end

  assign SRAM_DQ = oe_q ? dout_q : {DATA_W{1'bz}};

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready front end for a single-port asynchronous SRAM with byte masks and wait states.
//   state     | meaning
//   IDLE      | bus released, ready for a request
//   RD_ACC    | CE/OE low, waiting WAIT_CYCLES+1 cycles for read data
//   WR_SETUP  | address, byte lanes and data driven, WE_N still high
//   WR_STROBE | WE_N low for WAIT_CYCLES+1 cycles
//   WR_HOLD   | WE_N high, data held one more cycle
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                wr_done,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  inout  wire  [DATA_W-1:0]   SRAM_DQ,
  output logic                SRAM_WE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_CE_N,
  output logic [DATA_W/8-1:0] SRAM_BE_N
);

  localparam int BE_W = DATA_W / 8;

  sram_state_t       state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic [BE_W-1:0]   be_q, be_nxt;
  logic [DATA_W-1:0] be_mask;
  logic [DATA_W-1:0] din_q;
  logic              accept;
  logic              rd_cap;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    be_nxt       = be_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = req_we ? WR_SETUP : RD_ACC;
          wait_cnt_nxt = WAIT_W'(WAIT_CYCLES);
          addr_nxt     = req_addr;
          wdata_nxt    = req_wdata;
          be_nxt       = req_be;
        end
      end
      RD_ACC: begin
        if (wait_cnt == '0) state_nxt = IDLE;
        else                wait_cnt_nxt = wait_cnt - WAIT_W'(1);
      end
      WR_SETUP: state_nxt = WR_STROBE;
      WR_STROBE: begin
        if (wait_cnt == '0) state_nxt = WR_HOLD;
        else                wait_cnt_nxt = wait_cnt - WAIT_W'(1);
      end
      WR_HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < BE_W; i++) be_mask[i*8 +: 8] = {8{be_q[i]}};
  end

  // Pins are registered from the next state so they line up with the state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      req_ready <= 1'b0;
      rd_cap    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      wr_done   <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_N <= 1'b1;
      SRAM_OE_N <= 1'b1;
      SRAM_CE_N <= 1'b1;
      SRAM_BE_N <= '1;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      be_q      <= be_nxt;
      req_ready <= (state_nxt == IDLE);
      rd_cap    <= (state == RD_ACC) && (wait_cnt == '0);
      rsp_valid <= rd_cap;
      wr_done   <= (state == WR_HOLD);
      if (rd_cap) rsp_rdata <= din_q & be_mask;
      SRAM_CE_N <= (state_nxt == IDLE);
      SRAM_OE_N <= (state_nxt != RD_ACC);
      SRAM_WE_N <= (state_nxt != WR_STROBE);
      SRAM_BE_N <= (state_nxt == IDLE) ? '1 : ~be_nxt;
      if (state_nxt != IDLE) SRAM_ADDR <= addr_nxt;
    end
  end

  // Read data lands in the pad register on the last RD_ACC edge, one edge before rsp_valid.
  sram_dq_pad #(.DATA_W(DATA_W)) u_pad (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .dq_oe_nxt (drives_dq(state_nxt)),
    .dq_out_nxt(wdata_nxt),
    .dq_in     (din_q),
    .SRAM_DQ   (SRAM_DQ)
  );

endmodule
